// File: rtl/conv_mac_seq_if.sv
// Window-in / result-out handshake bundle for conv_mac_seq.
// The master drives windows and accepts results; the slave is the engine.
interface conv_mac_seq_if #(
  parameter int CH   = 3,
  parameter int K    = 5,
  parameter int DW   = 12,
  parameter int ACCW = 32,
  parameter int OW   = 14
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CH*K*K*DW-1:0]    in_data;
  logic signed [ACCW-1:0]  bias;
  logic                    relu_en;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OW-1:0]    out_data;
  logic                    sat_flag;

  modport master (
    output in_valid, in_data, bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/conv_mac_seq.sv
// Time-multiplexed K x K multi-channel convolution MAC with run-time weights.
// One channel per cycle, bias/shift/saturate/ReLU on the final sum.
module conv_mac_seq #(
  parameter int CH    = 3,
  parameter int K     = 5,
  parameter int DW    = 12,
  parameter int WW    = 8,
  parameter int ACCW  = 32,
  parameter int SHIFT = 6,
  parameter int OW    = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  conv_mac_seq_if.slave                 bus,
  input  logic                          w_we,
  input  logic [$clog2(CH*K*K)-1:0]     w_addr,
  input  logic signed [WW-1:0]          w_data,
  output logic                          w_err
);
  localparam int T  = K * K;
  localparam int N  = CH * T;
  localparam int AW = $clog2(N);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [ACCW-1:0] OMAX = ACCW'(2 ** (OW - 1) - 1);
  localparam logic signed [ACCW-1:0] OMIN = ~OMAX;

  logic [1:0]             state;
  logic [CW-1:0]          ch;
  logic [N*DW-1:0]        win;
  logic signed [ACCW-1:0] acc;
  logic                   relu_q;
  logic signed [WW-1:0]   w_mem [N];
  logic                   ov_q;
  logic signed [OW-1:0]   od_q;
  logic                   sat_q;

  logic                   st_idle;
  logic                   st_acc;
  logic                   st_done;
  logic                   last_ch;
  logic                   w_ok;
  logic signed [ACCW-1:0] psum;
  logic signed [ACCW-1:0] acc_nx;
  logic signed [ACCW-1:0] s;
  logic signed [OW-1:0]   res;
  logic                   sat;

  assign st_idle = (state == S_IDLE);
  assign st_acc  = (state == S_ACC);
  assign st_done = (state == S_DONE);
  assign last_ch = (ch == CW'(CH - 1));
  assign w_ok    = w_we && st_idle && (int'(w_addr) < N);

  assign bus.in_ready  = st_idle;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.sat_flag  = sat_q;

  // Dot product of the current channel's taps with its weights.
  always_comb begin
    psum = '0;
    for (int t = 0; t < T; t++) begin
      logic [AW-1:0]             idx;
      logic signed [DW+WW-1:0]   p;
      idx  = AW'(int'(ch) * T + t);
      p    = $signed(win[int'(idx)*DW +: DW]) * w_mem[idx];
      psum = psum + ACCW'(p);
    end
  end

  assign acc_nx = acc + psum;
  assign s      = acc_nx >>> SHIFT;

  always_comb begin
    res = s[OW-1:0];
    sat = 1'b0;
    if (s > OMAX) begin
      res = OMAX[OW-1:0];
      sat = 1'b1;
    end else if (s < OMIN) begin
      res = OMIN[OW-1:0];
      sat = 1'b1;
    end
    if (relu_q && res[OW-1]) res = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ch     <= '0;
      win    <= '0;
      acc    <= '0;
      relu_q <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      sat_q  <= 1'b0;
      w_err  <= 1'b0;
      for (int i = 0; i < N; i++) w_mem[i] <= '0;
    end else begin
      w_err <= w_we && !w_ok;
      if (w_ok) w_mem[w_addr] <= w_data;
      unique case (1'b1)
        st_idle: begin
          if (bus.in_valid) begin
            win    <= bus.in_data;
            acc    <= bus.bias;
            relu_q <= bus.relu_en;
            ch     <= '0;
            state  <= S_ACC;
          end
        end
        st_acc: begin
          acc <= acc_nx;
          ch  <= ch + 1'b1;
          if (last_ch) begin
            od_q  <= res;
            sat_q <= sat;
            ov_q  <= 1'b1;
            state <= S_DONE;
          end
        end
        st_done: begin
          if (bus.out_ready) begin
            ov_q  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_mac_seq.sv
// Randomised and directed bench for conv_mac_seq against an arithmetic
// reference model of the convolution sum.
module tb_conv_mac_seq;
  localparam int CH = 3, K = 5, DW = 12, WW = 8, ACCW = 32, SHIFT = 6, OW = 14;
  localparam int N = CH * K * K;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_we = 1'b0;
  logic [6:0] w_addr = '0;
  logic signed [WW-1:0] w_data = '0;
  logic w_err;

  conv_mac_seq_if #(.CH(CH), .K(K), .DW(DW), .ACCW(ACCW), .OW(OW)) bus ();

  conv_mac_seq #(
    .CH(CH), .K(K), .DW(DW), .WW(WW),
    .ACCW(ACCW), .SHIFT(SHIFT), .OW(OW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .w_we   (w_we),
    .w_addr (w_addr),
    .w_data (w_data),
    .w_err  (w_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int smp [N];
  int wm [N];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input longint b, input bit r,
                                output longint eo, output bit es);
    longint a;
    longint q;
    a = b;
    for (int i = 0; i < N; i++) a += longint'(smp[i]) * wm[i];
    q = a / 64;
    if ((a % 64) != 0 && a < 0) q = q - 1;
    es = 1'b0;
    if (q > 8191) begin
      q = 8191;
      es = 1'b1;
    end else if (q < -8192) begin
      q = -8192;
      es = 1'b1;
    end
    if (r && q < 0) q = 0;
    eo = q;
  endfunction

  function automatic logic [N*DW-1:0] pack();
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(smp[i]);
    return v;
  endfunction

  task automatic wr(input int a, input int v);
    logic signed [7:0] tv;
    tv = 8'(v);
    w_we = 1'b1;
    w_addr = 7'(a);
    w_data = tv;
    wm[a] = int'(tv);
    step();
    w_we = 1'b0;
  endtask

  task automatic load_all(input int v);
    for (int i = 0; i < N; i++) wr(i, v);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) smp[i] = v;
  endtask

  task automatic accept(input int b, input bit r);
    bus.in_data = pack();
    bus.bias = b;
    bus.relu_en = r;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int b, input bit r,
                         input int exp_lat, input bit hs);
    int lat;
    longint eo;
    bit es;
    model(b, r, eo, es);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.out_valid && lat < 20);
    if (!bus.out_valid) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_data"}, longint'(bus.out_data), eo);
      chk({tag, "_sat"}, bus.sat_flag, es);
    end
    if (hs) begin
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.bias = '0;
    bus.relu_en = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) wm[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_od", longint'(bus.out_data), 0);
    chk("rst_werr", w_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_rdy", bus.in_ready, 1);

    load_all(1);
    fill(64);
    accept(0, 1'b0);
    collect("nominal", 0, 1'b0, 3, 1'b1);

    // Async reset in the middle of accumulation
    accept(0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_od", longint'(bus.out_data), 0);
    chk("mid_rst_werr", w_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) wm[i] = 0;
    step();
    chk("mid_rst_rdy", bus.in_ready, 1);
    accept(0, 1'b0);
    collect("zero_w", 0, 1'b0, 3, 1'b1);

    load_all(-1);
    accept(0, 1'b0);
    collect("neg", 0, 1'b0, 3, 1'b1);
    accept(0, 1'b1);
    collect("relu", 0, 1'b1, 3, 1'b1);
    accept(6400, 1'b0);
    collect("bias", 6400, 1'b0, 3, 1'b1);

    load_all(127);
    fill(2047);
    accept(0, 1'b0);
    collect("sat_pos", 0, 1'b0, 3, 1'b1);
    load_all(-128);
    accept(0, 1'b0);
    collect("sat_neg", 0, 1'b0, 3, 1'b1);

    // Backpressure with a second window waiting
    load_all(1);
    fill(64);
    accept(0, 1'b0);
    collect("bp_a", 0, 1'b0, 3, 1'b0);
    for (int i = 0; i < N; i++) smp[i] = int'($signed(12'($urandom)));
    bus.in_data = pack();
    bus.bias = '0;
    bus.relu_en = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rdy", bus.in_ready, 0);
      chk("bp_ov", bus.out_valid, 1);
      chk("bp_hold", longint'(bus.out_data), 75);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_hs_ov", bus.out_valid, 0);
    chk("bp_hs_rdy", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_b_rdy", bus.in_ready, 0);
    collect("bp_b", 0, 1'b0, 3, 1'b1);

    // Dropped weight writes
    fill(64);
    w_we = 1'b1;
    w_addr = 7'd75;
    w_data = 8'sd9;
    step();
    w_we = 1'b0;
    chk("werr_addr", w_err, 1);
    step();
    chk("werr_addr_clr", w_err, 0);
    accept(0, 1'b0);
    w_we = 1'b1;
    w_addr = 7'd0;
    w_data = 8'sd5;
    step();
    w_we = 1'b0;
    chk("werr_acc", w_err, 1);
    step();
    chk("werr_acc_clr", w_err, 0);
    collect("werr_win", 0, 1'b0, 1, 1'b1);
    accept(0, 1'b0);
    collect("werr_nom", 0, 1'b0, 3, 1'b1);

    for (int it = 0; it < 25; it++) begin
      int b;
      bit r;
      for (int j = 0; j < 10; j++)
        wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      for (int i = 0; i < N; i++) begin
        if (it < 12) smp[i] = int'($urandom_range(0, 400)) - 200;
        else smp[i] = int'($signed(12'($urandom)));
      end
      b = int'($urandom_range(0, 200000)) - 100000;
      r = 1'($urandom);
      accept(b, r);
      collect("rand", b, r, 3, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
